// File: rtl/load_vector.sv
// Streams a vector from DRAM one element at a time, packs elements into
// fixed-width tiles and hands each tile to the vector buffer file.
module load_vector #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8,
  parameter int TILE_WIDTH = 256,
  parameter int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [ADDR_WIDTH-1:0]                 dram_addr,
  input  logic [9:0]                            length,
  input  logic [4:0]                            buf_id,
  output logic                                  mem_req,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata,
  input  logic                                  mem_valid,
  output logic                                  buf_write_en,
  output logic [4:0]                            buf_write_id,
  output logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] buf_write_data,
  input  logic                                  buf_write_done,
  output logic                                  busy,
  output logic                                  done
);

  localparam int IDX_W = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILE_ELEMS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_REQ,
    S_READ_WAIT,
    S_WRITE_TILE,
    S_WAIT_BUF,
    S_FINISH
  } state_t;

  state_t                                state_q, state_d;
  logic [ADDR_WIDTH-1:0]                 base_q, base_d;
  logic [9:0]                            len_q, len_d;
  logic [10:0]                           count_q, count_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic [4:0]                            id_d;
  logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] tile_d;
  logic                                  buf_accept;

  // The tile register doubles as buf_write_data: it is untouched between the
  // write pulse and the buffer acknowledge, so the data holds stable.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    count_d    = count_q;
    idx_d      = idx_q;
    id_d       = buf_write_id;
    tile_d     = buf_write_data;
    buf_accept = buf_write_done &&
                 (state_q == S_WRITE_TILE || state_q == S_WAIT_BUF);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = dram_addr;
          len_d   = length;
          id_d    = buf_id;
          count_d = '0;
          idx_d   = '0;
          tile_d  = '0;
          state_d = (length == 10'd0) ? S_FINISH : S_READ_REQ;
        end
      end
      S_READ_REQ:   state_d = S_READ_WAIT;
      S_READ_WAIT: begin
        if (mem_valid) begin
          tile_d[idx_q] = mem_rdata;
          count_d       = count_q + 11'd1;
          idx_d         = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX || count_d == {1'b0, len_q})
            state_d = S_WRITE_TILE;
          else
            state_d = S_READ_REQ;
        end
      end
      S_WRITE_TILE: state_d = S_WAIT_BUF;
      S_WAIT_BUF:   state_d = S_WAIT_BUF;
      S_FINISH:     state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase

    // The buffer may acknowledge in the same cycle as the write pulse.
    if (buf_accept) begin
      if (count_q == {1'b0, len_q}) begin
        state_d = S_FINISH;
      end else begin
        state_d = S_READ_REQ;
        tile_d  = '0;
        idx_d   = '0;
      end
    end
  end

  // Outputs are decoded from the next state so every one comes from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      base_q         <= '0;
      len_q          <= '0;
      count_q        <= '0;
      idx_q          <= '0;
      buf_write_id   <= '0;
      buf_write_data <= '0;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
      buf_write_en   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      len_q          <= len_d;
      count_q        <= count_d;
      idx_q          <= idx_d;
      buf_write_id   <= id_d;
      buf_write_data <= tile_d;
      mem_req        <= (state_d == S_READ_REQ);
      mem_addr       <= (state_d == S_READ_REQ) ? base_d + ADDR_WIDTH'(count_d) : '0;
      buf_write_en   <= (state_d == S_WRITE_TILE);
      busy           <= (state_d != S_IDLE);
      done           <= (state_d == S_FINISH);
    end
  end

endmodule

// File: tb/tb_load_vector.sv
// Randomised self-checking bench for load_vector: a memory and buffer-file
// model respond to the DUT, and a tile-level reference predicts the results.
module tb_load_vector;

  localparam int AW = 24;
  localparam int DW = 8;
  localparam int TE = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [AW-1:0]         dram_addr = '0;
  logic [9:0]            length = '0;
  logic [4:0]            buf_id = '0;
  logic                  mem_req;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_rdata = '0;
  logic                  mem_valid = 1'b0;
  logic                  buf_write_en;
  logic [4:0]            buf_write_id;
  logic [TE-1:0][DW-1:0] buf_write_data;
  logic                  buf_write_done = 1'b0;
  logic                  busy;
  logic                  done;

  always #5 clk = ~clk;

  load_vector #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TILE_WIDTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .dram_addr(dram_addr),
    .length(length), .buf_id(buf_id), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .buf_write_en(buf_write_en),
    .buf_write_id(buf_write_id), .buf_write_data(buf_write_data),
    .buf_write_done(buf_write_done), .busy(busy), .done(done)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Environment configuration for the memory and buffer responders.
  int         lat_min = 0, lat_max = 0;
  int         bw_delay_cfg = 1;
  bit         stray_en = 1'b0;
  logic [7:0] key = 8'h00;

  function automatic logic [7:0] memData(input logic [AW-1:0] a, input logic [7:0] k);
    return a[7:0] ^ k;
  endfunction

  // Observation state.
  logic [AW-1:0] addr_q[$];
  logic [255:0]  tile_q[$];
  logic [4:0]    tid_q[$];
  logic          stab_q[$];
  int req_cnt, en_cnt, done_cnt, busy_cnt, valid_cnt, mem_overlap, bw_overlap;

  logic          mem_pending = 1'b0;
  int            mem_delay;
  logic [AW-1:0] mem_cur_addr;
  logic          bw_pending = 1'b0;
  int            bw_delay, bw_d;
  logic [255:0]  bw_data;
  logic          bw_unstable;

  // Memory and buffer-file responders; inputs change on the falling edge.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (rst) begin
      mem_pending    = 1'b0;
      bw_pending     = 1'b0;
      mem_valid      = 1'b0;
      buf_write_done = 1'b0;
    end else begin
      mem_valid      = 1'b0;
      mem_rdata      = 8'($urandom);
      buf_write_done = 1'b0;
      if (mem_pending) begin
        if (mem_delay == 0) begin
          mem_valid   = 1'b1;
          mem_rdata   = memData(mem_cur_addr, key);
          mem_pending = 1'b0;
          valid_cnt++;
        end else begin
          mem_delay--;
        end
      end else if (stray_en && !mem_req && $urandom_range(0, 3) == 0) begin
        mem_valid = 1'b1;
      end
      if (mem_req) begin
        req_cnt++;
        addr_q.push_back(mem_addr);
        if (mem_pending) mem_overlap++;
        mem_pending  = 1'b1;
        mem_cur_addr = mem_addr;
        mem_delay    = $urandom_range(lat_min, lat_max);
      end

      if (bw_pending) begin
        if (256'(buf_write_data) !== bw_data) bw_unstable = 1'b1;
        if (bw_delay == 0) begin
          buf_write_done = 1'b1;
          bw_pending     = 1'b0;
          stab_q.push_back(bw_unstable);
        end else begin
          bw_delay--;
        end
      end
      if (buf_write_en) begin
        en_cnt++;
        if (bw_pending) bw_overlap++;
        tile_q.push_back(buf_write_data);
        tid_q.push_back(buf_write_id);
        bw_data     = buf_write_data;
        bw_unstable = 1'b0;
        bw_d = (bw_delay_cfg < 0) ? $urandom_range(0, 4) : bw_delay_cfg;
        if (bw_d == 0) begin
          buf_write_done = 1'b1;
          bw_pending     = 1'b0;
          stab_q.push_back(1'b0);
        end else begin
          bw_pending = 1'b1;
          bw_delay   = bw_d - 1;
        end
      end
    end
  end

  task automatic clearObs();
    addr_q.delete(); tile_q.delete(); tid_q.delete(); stab_q.delete();
    req_cnt = 0; en_cnt = 0; done_cnt = 0; busy_cnt = 0; valid_cnt = 0;
    mem_overlap = 0; bw_overlap = 0;
  endtask

  // Reference tile: element j of tile t is memory at base+32t+j, or zero
  // once past the end of the vector.
  function automatic logic [255:0] expTile(input logic [AW-1:0] base, input int len,
                                           input int t, input logic [7:0] k);
    logic [255:0]  r = '0;
    logic [AW-1:0] a;
    for (int j = 0; j < TE; j++) begin
      if (t * TE + j < len) begin
        a = base + AW'(t * TE + j);
        r[j*8 +: 8] = memData(a, k);
      end
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic [AW-1:0] base, input int len,
                               input logic [4:0] id, input bit noise);
    int cyc = 0;
    int bound = 16 * len + 200;
    @(negedge clk); #1;
    clearObs();
    dram_addr = base; length = 10'(len); buf_id = id; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    while (done_cnt == 0 && cyc < bound) begin
      if (noise && busy) begin
        start     = 1'($urandom_range(0, 1));
        dram_addr = AW'($urandom);
        length    = 10'($urandom);
        buf_id    = 5'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic checkLoad(input string name, input logic [AW-1:0] base, input int len,
                           input logic [4:0] id, input bit timing);
    int ntiles = (len + TE - 1) / TE;
    int bad = 0;
    logic [AW-1:0] ea;
    checkOutput({name, ".done_count"}, done_cnt, 1);
    checkOutput({name, ".req_count"}, req_cnt, len);
    for (int i = 0; i < len; i++) begin
      ea = base + AW'(i);
      if (i >= addr_q.size()) bad++;
      else if (addr_q[i] !== ea) bad++;
    end
    checkOutput({name, ".addr_errors"}, bad, 0);
    checkOutput({name, ".tile_count"}, tile_q.size(), ntiles);
    for (int t = 0; t < ntiles && t < tile_q.size(); t++) begin
      checkOutput($sformatf("%s.tile%0d", name, t), tile_q[t], expTile(base, len, t, key));
      checkOutput($sformatf("%s.id%0d", name, t), tid_q[t], id);
      if (t < stab_q.size())
        checkOutput($sformatf("%s.unstable%0d", name, t), stab_q[t], 0);
    end
    checkOutput({name, ".overlaps"}, mem_overlap + bw_overlap, 0);
    if (timing)
      checkOutput({name, ".busy_cycles"}, busy_cnt, 2 * len + 2 * ntiles + 1);
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW-1:0] rb;
    int rl, cyc, req_at_rst;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset.outputs", {mem_req, mem_addr, buf_write_en, buf_write_id, busy, done}, 0);
    checkOutput("reset.wdata", buf_write_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // Zero-latency directed loads with exact cycle budgets.
    applyStimulus(24'h000100, 32, 5'd3, 1'b0);
    checkLoad("full_tile", 24'h000100, 32, 5'd3, 1'b1);
    applyStimulus(24'h000200, 40, 5'd9, 1'b0);
    checkLoad("partial", 24'h000200, 40, 5'd9, 1'b1);
    applyStimulus(24'h000500, 0, 5'd1, 1'b0);
    checkLoad("empty", 24'h000500, 0, 5'd1, 1'b1);

    // Slow memory with stray valid pulses must give identical tiles.
    lat_min = 0; lat_max = 4; stray_en = 1'b1;
    applyStimulus(24'h000200, 40, 5'd9, 1'b0);
    checkLoad("slow_mem", 24'h000200, 40, 5'd9, 1'b0);

    // Delayed acknowledge with start hammered while busy.
    bw_delay_cfg = 4;
    applyStimulus(24'h000400, 70, 5'd17, 1'b1);
    checkLoad("slow_buf", 24'h000400, 70, 5'd17, 1'b0);

    // Acknowledge in the same cycle as the write pulse.
    lat_min = 0; lat_max = 0; stray_en = 1'b0; bw_delay_cfg = 0;
    applyStimulus(24'h000800, 33, 5'd30, 1'b0);
    checkLoad("same_cycle_ack", 24'h000800, 33, 5'd30, 1'b0);

    // Maximum length wrapping through the top of the address space.
    bw_delay_cfg = 1; key = 8'h3C;
    applyStimulus(24'hFFFF80, 1023, 5'd31, 1'b0);
    checkLoad("max_len", 24'hFFFF80, 1023, 5'd31, 1'b1);

    for (int n = 0; n < 6; n++) begin
      rb = AW'($urandom);
      rl = $urandom_range(1, 130);
      key = 8'($urandom);
      lat_min = 0; lat_max = $urandom_range(0, 4);
      stray_en = 1'($urandom_range(0, 1));
      bw_delay_cfg = -1;
      applyStimulus(rb, rl, 5'(n + 4), 1'($urandom_range(0, 1)));
      checkLoad($sformatf("rand%0d", n), rb, rl, 5'(n + 4), 1'b0);
    end

    // Abort a load mid-flight, then confirm a clean restart.
    lat_min = 0; lat_max = 0; stray_en = 1'b0; bw_delay_cfg = 1; key = 8'h00;
    @(negedge clk); #1;
    clearObs();
    dram_addr = 24'h000300; length = 10'd64; buf_id = 5'd7; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (valid_cnt < 10 && cyc < 500) begin
      @(negedge clk); #1;
      cyc++;
    end
    checkOutput("abort.progress", valid_cnt, 10);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    req_at_rst = req_cnt;
    checkOutput("abort.outputs", {mem_req, mem_addr, buf_write_en, buf_write_id, busy, done}, 0);
    checkOutput("abort.wdata", buf_write_data, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("abort.no_done", done_cnt, 0);
    checkOutput("abort.no_req", req_cnt, req_at_rst);
    checkOutput("abort.no_write", en_cnt, 0);
    applyStimulus(24'h000100, 32, 5'd2, 1'b0);
    checkLoad("after_abort", 24'h000100, 32, 5'd2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
